// File: rtl/ram_pkg.sv
// Shared types and helpers for the byte-enable simple-dual-port RAM.
// Holds the clear FSM encoding, read-during-write selectors and byte merge.
package ram_pkg;

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } clr_state_t;

    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

    // Widest word the merge helper handles; callers cast in and out.
    localparam int MERGE_W = 1024;

    function automatic logic [MERGE_W-1:0] byte_merge(
        input logic [MERGE_W-1:0]   old_w,
        input logic [MERGE_W-1:0]   new_w,
        input logic [MERGE_W/8-1:0] be
    );
        logic [MERGE_W-1:0] res;
        res = old_w;
        for (int i = 0; i < MERGE_W/8; i++) begin
            if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/ram_clr_ctrl.sv
// Sequenced array clear: walks every word once after reset or on request.
// Busy and the clear write strobe stay high for exactly MEM_DEPTH edges.
module ram_clr_ctrl
    import ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int MEM_DEPTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr_req,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] clr_addr,
    output logic                  clr_we
);

    localparam logic [ADDR_WIDTH:0] LAST = (ADDR_WIDTH+1)'(MEM_DEPTH - 1);

    clr_state_t          state;
    logic [ADDR_WIDTH:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_CLEAR;
            cnt   <= '0;
            busy  <= 1'b1;
        end else begin
            unique case (state)
                ST_CLEAR: begin
                    if (cnt == LAST) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (clr_req) begin
                        state <= ST_CLEAR;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign clr_we   = (state == ST_CLEAR);
    assign clr_addr = cnt[ADDR_WIDTH-1:0];

endmodule

// File: rtl/ram_sdp_be_clr.sv
// Simple-dual-port RAM with byte enables, 1/2-cycle read latency,
// selectable read-during-write policy and a sequenced hardware clear.
module ram_sdp_be_clr
    import ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int MEM_DEPTH  = 16,
    parameter int MEM_WIDTH  = 16,
    parameter int RD_LATENCY = 1,
    parameter int RDW_MODE   = 0
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   WrEn,
    input  logic [ADDR_WIDTH-1:0]  WrAddr,
    input  logic [MEM_WIDTH-1:0]   WrData,
    input  logic [MEM_WIDTH/8-1:0] WrBe,
    input  logic                   RdEn,
    input  logic [ADDR_WIDTH-1:0]  RdAddr,
    output logic [MEM_WIDTH-1:0]   RdData,
    output logic                   RdValid,
    input  logic                   ClrReq,
    output logic                   Busy,
    output logic                   AddrErr
);

    localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH+1)'(MEM_DEPTH);

    logic [MEM_WIDTH-1:0]  mem [MEM_DEPTH];
    logic                  busy;
    logic                  clr_we;
    logic [ADDR_WIDTH-1:0] clr_addr;

    ram_clr_ctrl #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH)
    ) u_ctrl (
        .clk      (CLK),
        .rst_n    (RST),
        .clr_req  (ClrReq),
        .busy     (busy),
        .clr_addr (clr_addr),
        .clr_we   (clr_we)
    );

    assign Busy = busy;

    logic wr_acc, rd_acc, wr_ok, rd_ok;
    logic [MEM_WIDTH-1:0] wr_old, wr_word, rd_word;

    assign wr_acc = WrEn && !busy;
    assign rd_acc = RdEn && !busy;
    assign wr_ok  = {1'b0, WrAddr} < DEPTH;
    assign rd_ok  = {1'b0, RdAddr} < DEPTH;
    assign wr_old = wr_ok ? mem[WrAddr] : '0;
    assign wr_word = MEM_WIDTH'(byte_merge(MERGE_W'(wr_old),
                                           MERGE_W'(WrData),
                                           (MERGE_W/8)'(WrBe)));

    always_comb begin
        rd_word = '0;
        if (rd_ok) rd_word = mem[RdAddr];
        // Write-through: forward the merged word to a same-address read.
        if (RDW_MODE == RDW_NEW && wr_acc && wr_ok && WrAddr == RdAddr)
            rd_word = wr_word;
    end

    // Clear and port writes never coincide: writes are refused while busy.
    always_ff @(posedge CLK) begin
        if (clr_we) mem[clr_addr] <= '0;
        else if (wr_acc && wr_ok) mem[WrAddr] <= wr_word;
    end

    logic                 v1;
    logic [MEM_WIDTH-1:0] d1;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            v1      <= 1'b0;
            d1      <= '0;
            AddrErr <= 1'b0;
        end else begin
            v1      <= rd_acc;
            AddrErr <= (wr_acc && !wr_ok) || (rd_acc && !rd_ok);
            if (rd_acc) d1 <= rd_word;
        end
    end

    generate
        if (RD_LATENCY == 2) begin : g_lat2
            logic                 v2;
            logic [MEM_WIDTH-1:0] d2;
            always_ff @(posedge CLK or negedge RST) begin
                if (!RST) begin
                    v2 <= 1'b0;
                    d2 <= '0;
                end else begin
                    v2 <= v1;
                    if (v1) d2 <= d1;
                end
            end
            assign RdValid = v2;
            assign RdData  = d2;
        end else begin : g_lat1
            assign RdValid = v1;
            assign RdData  = d1;
        end
    endgenerate

endmodule

// File: tb/tb_ram_sdp_be_clr.sv
// Bench for ram_sdp_be_clr: two configurations driven in lockstep,
// each compared against a transaction-level model of the RAM.
module tb_ram_sdp_be_clr;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0, rd_en = 1'b0, clr_req = 1'b0;
    logic [3:0]  wr_addr = '0, rd_addr = '0;
    logic [15:0] wr_data = '0;
    logic [1:0]  wr_be = '0;

    logic [15:0] rd_data_a, rd_data_b;
    logic        rd_valid_a, rd_valid_b, busy_a, busy_b, err_a, err_b;

    always #5 clk = ~clk;

    ram_sdp_be_clr #(
        .ADDR_WIDTH(4), .MEM_DEPTH(16), .MEM_WIDTH(16),
        .RD_LATENCY(1), .RDW_MODE(0)
    ) dut_a (
        .CLK(clk), .RST(rst), .WrEn(wr_en), .WrAddr(wr_addr),
        .WrData(wr_data), .WrBe(wr_be), .RdEn(rd_en), .RdAddr(rd_addr),
        .RdData(rd_data_a), .RdValid(rd_valid_a), .ClrReq(clr_req),
        .Busy(busy_a), .AddrErr(err_a)
    );

    ram_sdp_be_clr #(
        .ADDR_WIDTH(4), .MEM_DEPTH(12), .MEM_WIDTH(16),
        .RD_LATENCY(2), .RDW_MODE(1)
    ) dut_b (
        .CLK(clk), .RST(rst), .WrEn(wr_en), .WrAddr(wr_addr),
        .WrData(wr_data), .WrBe(wr_be), .RdEn(rd_en), .RdAddr(rd_addr),
        .RdData(rd_data_b), .RdValid(rd_valid_b), .ClrReq(clr_req),
        .Busy(busy_b), .AddrErr(err_b)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int depth [2] = '{16, 12};
    int lat   [2] = '{1, 2};
    int rdw   [2] = '{0, 1};

    typedef struct {
        int          due;
        logic [15:0] d;
    } rd_t;

    logic [15:0] mm [2][16];
    int          clr_left [2];
    rd_t         q0 [$];
    rd_t         q1 [$];
    logic        e_busy [2], e_valid [2], e_err [2];
    logic [15:0] e_data [2];

    function automatic logic [15:0] merge(input logic [15:0] o,
                                          input logic [15:0] n,
                                          input logic [1:0]  be);
        logic [15:0] r;
        r = o;
        for (int b = 0; b < 2; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    task automatic chk(input string tag, input int c,
                       input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s dut%0d obs=%h exp=%h t=%0t", tag, c, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            clr_left[c] = depth[c];
            e_busy[c]   = 1'b1;
            e_valid[c]  = 1'b0;
            e_err[c]    = 1'b0;
            e_data[c]   = '0;
        end
        q0.delete();
        q1.delete();
    endtask

    task automatic model_edge();
        rd_t         r;
        logic        wok, rok;
        logic [15:0] v;
        cyc++;
        for (int c = 0; c < 2; c++) begin
            if (clr_left[c] > 0) begin
                mm[c][depth[c] - clr_left[c]] = '0;
                clr_left[c]--;
                e_err[c] = 1'b0;
            end else begin
                wok = wr_en && (int'(wr_addr) < depth[c]);
                rok = rd_en && (int'(rd_addr) < depth[c]);
                e_err[c] = (wr_en && !wok) || (rd_en && !rok);
                if (rd_en) begin
                    v = rok ? mm[c][rd_addr] : 16'h0000;
                    if (rdw[c] == 1 && wok && wr_addr == rd_addr)
                        v = merge(mm[c][rd_addr], wr_data, wr_be);
                    r.due = cyc + lat[c] - 1;
                    r.d   = v;
                    if (c == 0) q0.push_back(r);
                    else q1.push_back(r);
                end
                if (wok) mm[c][wr_addr] = merge(mm[c][wr_addr], wr_data, wr_be);
                if (clr_req) clr_left[c] = depth[c];
            end
            e_busy[c]  = clr_left[c] > 0;
            e_valid[c] = 1'b0;
            if (c == 0 && q0.size() > 0 && q0[0].due == cyc) begin
                e_valid[c] = 1'b1;
                e_data[c]  = q0[0].d;
                void'(q0.pop_front());
            end
            if (c == 1 && q1.size() > 0 && q1[0].due == cyc) begin
                e_valid[c] = 1'b1;
                e_data[c]  = q1[0].d;
                void'(q1.pop_front());
            end
        end
    endtask

    task automatic check_all();
        chk("busy",  0, 16'(busy_a),     16'(e_busy[0]));
        chk("valid", 0, 16'(rd_valid_a), 16'(e_valid[0]));
        chk("data",  0, rd_data_a,       e_data[0]);
        chk("err",   0, 16'(err_a),      16'(e_err[0]));
        chk("busy",  1, 16'(busy_b),     16'(e_busy[1]));
        chk("valid", 1, 16'(rd_valid_b), 16'(e_valid[1]));
        chk("data",  1, rd_data_b,       e_data[1]);
        chk("err",   1, 16'(err_b),      16'(e_err[1]));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle();
        wr_en = 1'b0; rd_en = 1'b0; clr_req = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d,
                      input logic [1:0] be);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
    endtask

    task automatic rd(input logic [3:0] a);
        rd_en = 1'b1; rd_addr = a;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_all();
    endtask

    // Runs n edges with inputs as they stand; counts edges that see Busy
    // and records the first step after which RdValid is high.
    task automatic clear_run(input int n, output int ba, output int bb,
                             output int fa, output int fb);
        ba = 0; bb = 0; fa = 0; fb = 0;
        for (int i = 1; i <= n; i++) begin
            ba += int'(busy_a);
            bb += int'(busy_b);
            step();
            if (fa == 0 && rd_valid_a) fa = i;
            if (fb == 0 && rd_valid_b) fb = i;
        end
    endtask

    initial begin
        int ba, bb, fa, fb;

        #2;
        do_reset();

        rd(4'd3);
        clear_run(20, ba, bb, fa, fb);
        chk("busy_edges", 0, 16'(ba), 16'd16);
        chk("busy_edges", 1, 16'(bb), 16'd12);
        chk("first_valid_step", 0, 16'(fa), 16'd17);
        chk("first_valid_step", 1, 16'(fb), 16'd14);
        idle();
        step();
        step();

        wr(4'd2, 16'hA5A5, 2'b11); step();
        wr(4'd2, 16'h3C3C, 2'b01); step();
        idle(); rd(4'd2); step();
        chk("be_merge", 0, rd_data_a, 16'hA53C);
        idle(); step();
        chk("be_merge", 1, rd_data_b, 16'hA53C);

        wr(4'd5, 16'h1111, 2'b11); step();
        wr(4'd5, 16'h2222, 2'b11); rd(4'd5); step();
        chk("rdw_same_cycle", 0, rd_data_a, 16'h1111);
        idle(); rd(4'd5); step();
        chk("rdw_after", 0, rd_data_a, 16'h2222);
        chk("rdw_same_cycle", 1, rd_data_b, 16'h2222);
        idle(); step();
        chk("rdw_after", 1, rd_data_b, 16'h2222);

        for (int i = 0; i < 3; i++) begin
            wr(4'(i), 16'h0010 + 16'(i), 2'b11);
            step();
        end
        idle();
        for (int i = 0; i < 5; i++) begin
            idle();
            if (i < 3) rd(4'(i));
            step();
            if (i >= 1 && i <= 3) begin
                chk("lat2_valid", 1, 16'(rd_valid_b), 16'd1);
                chk("lat2_data", 1, rd_data_b, 16'h0010 + 16'(i - 1));
            end else begin
                chk("lat2_valid", 1, 16'(rd_valid_b), 16'd0);
            end
        end

        wr(4'd13, 16'hFFFF, 2'b11); step();
        chk("oor_wr_err", 1, 16'(err_b), 16'd1);
        idle(); rd(4'd13); step();
        chk("oor_rd_err", 1, 16'(err_b), 16'd1);
        idle(); step();
        chk("oor_rd_valid", 1, 16'(rd_valid_b), 16'd1);
        chk("oor_rd_data", 1, rd_data_b, 16'h0000);
        for (int i = 0; i < 12; i++) begin
            idle(); rd(4'(i)); step();
        end
        idle(); step(); step();

        for (int i = 0; i < 16; i++) begin
            wr(4'(i), 16'h00FF, 2'b11);
            step();
        end
        idle(); clr_req = 1'b1; step();
        idle();
        repeat (5) step();
        clr_req = 1'b1; step();
        idle();
        repeat (3) step();
        do_reset();
        clear_run(20, ba, bb, fa, fb);
        chk("reclear_busy_edges", 0, 16'(ba), 16'd16);
        chk("reclear_busy_edges", 1, 16'(bb), 16'd12);
        for (int i = 0; i < 16; i++) begin
            idle(); rd(4'(i)); step();
        end
        idle(); step(); step();

        for (int i = 0; i < 400; i++) begin
            wr_en   = 1'($urandom_range(0, 1));
            wr_addr = 4'($urandom_range(0, 15));
            wr_data = 16'($urandom);
            wr_be   = 2'($urandom_range(0, 3));
            rd_en   = 1'($urandom_range(0, 1));
            rd_addr = ($urandom_range(0, 3) == 0) ? wr_addr
                                                  : 4'($urandom_range(0, 15));
            clr_req = ($urandom_range(0, 59) == 0);
            step();
        end
        idle();
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
